// File: rtl/mem_adaptor_pkg.sv
// Shared types and helpers for the memory adaptor: FSM states, access size
// codes, the size-to-byte-count mapping and the default IO space selector.
package mem_adaptor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // addr[17:16] value that marks the UART / IO window
    localparam logic [1:0] IO_SEL_SPACE = 2'b11;

    // Number of bus bytes moved for a given size code (unused code 11 behaves as a word)
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memory_adaptor.sv
// Memory adaptor: serialises instruction-cache fetches and LSB loads/stores
// onto the 8-bit RAM/IO bus, one byte per cycle, and hands back assembled
// little-endian results together with single-cycle done pulses.
module memory_adaptor
    import mem_adaptor_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_SEL = IO_SEL_SPACE
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_pipline,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              request_ins_from_memory_adaptor,
    input  logic [31:0]       insaddr_to_be_fetched_from_memory_adaptor,
    output logic [31:0]       ins_fetched_from_memory_adaptor,
    output logic              insfetch_task_done,
    input  logic              data_request,
    input  logic              data_is_write,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_task_done,
    output logic              adaptor_busy
);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic              is_ins_q, is_ins_d;
    logic [31:0]       base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       result_q, result_d;
    logic [31:0]       ins_q, ins_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              pend_ins_q, pend_ins_d;
    logic [31:0]       pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;

    logic [31:0]       cur_addr;
    logic [1:0]        cap_idx;
    logic              io_stall;
    logic              ins_avail;
    logic              accept_ins;
    logic              drive_addr;
    logic              drive_data;
    logic              wr_strobe;
    logic              ins_done;
    logic              data_done;

    // Byte address of the current beat; wraps modulo 2^32
    assign cur_addr  = base_q + {29'd0, cnt_q};
    // Beat k returns the byte requested at beat k-1 (2-bit wrap maps cnt 4 to byte 3)
    assign cap_idx   = cnt_q[1:0] - 2'd1;
    assign io_stall  = (cur_addr[17:16] == IO_SEL) && io_buffer_full;
    // A fetch is serviceable from the latch or straight from this cycle's pulse
    assign ins_avail = !flush_pipline &&
                       (pend_ins_q || request_ins_from_memory_adaptor);

    // Next-state, datapath capture and bus control for the transaction FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nbytes_d   = nbytes_q;
        is_ins_d   = is_ins_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        result_d   = result_q;
        ins_d      = ins_q;
        rdata_d    = rdata_q;
        accept_ins = 1'b0;
        drive_addr = 1'b0;
        drive_data = 1'b0;
        wr_strobe  = 1'b0;
        ins_done   = 1'b0;
        data_done  = 1'b0;

        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    // Data requests win; a fetch waits in the latch meanwhile
                    if (data_request) begin
                        base_d   = data_addr;
                        nbytes_d = size_to_bytes(data_size);
                        is_ins_d = 1'b0;
                        wdata_d  = data_wdata;
                        result_d = 32'd0;
                        cnt_d    = 3'd0;
                        state_d  = data_is_write ? ST_WRITE : ST_READ;
                    end else if (ins_avail) begin
                        base_d     = request_ins_from_memory_adaptor ?
                                     insaddr_to_be_fetched_from_memory_adaptor :
                                     pend_addr_q;
                        nbytes_d   = 3'd4;
                        is_ins_d   = 1'b1;
                        result_d   = 32'd0;
                        cnt_d      = 3'd0;
                        state_d    = ST_READ;
                        accept_ins = 1'b1;
                    end
                end

                ST_READ: begin
                    if (is_ins_q && flush_pipline) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            result_d[{cap_idx, 3'b000} +: 8] = mem_din;
                        end
                        if (cnt_q == nbytes_q) begin
                            state_d = ST_RESP;
                            if (is_ins_q) begin
                                ins_d = result_d;
                            end else begin
                                rdata_d = result_d;
                            end
                        end else begin
                            drive_addr = 1'b1;
                            cnt_d      = cnt_q + 3'd1;
                        end
                    end
                end

                ST_WRITE: begin
                    drive_addr = 1'b1;
                    drive_data = 1'b1;
                    // A full UART buffer holds the byte on the bus without strobing
                    if (!io_stall) begin
                        wr_strobe = 1'b1;
                        if (cnt_q == nbytes_q - 3'd1) begin
                            state_d = ST_RESP;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end

                default: begin
                    // A fetch flushed while its result is being returned is dropped too
                    state_d = ST_IDLE;
                    if (is_ins_q) begin
                        ins_done = !flush_pipline;
                    end else begin
                        data_done = 1'b1;
                    end
                end
            endcase
        end
    end

    // Pending-fetch latch: catches the one-cycle icache pulse until it is serviced
    always_comb begin
        pend_ins_d  = pend_ins_q;
        pend_addr_d = pend_addr_q;
        if (flush_pipline || accept_ins) begin
            pend_ins_d = 1'b0;
        end else if (request_ins_from_memory_adaptor) begin
            pend_ins_d  = 1'b1;
            pend_addr_d = insaddr_to_be_fetched_from_memory_adaptor;
        end
    end

    // Bus outputs: drive the current beat, otherwise hold the last driven value
    always_comb begin
        mem_a_d    = drive_addr ? cur_addr[ADDR_W-1:0] : mem_a_q;
        mem_dout_d = drive_data ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : mem_dout_q;
    end

    assign mem_a                           = mem_a_d;
    assign mem_dout                        = mem_dout_d;
    assign mem_wr                          = wr_strobe;
    assign insfetch_task_done              = ins_done;
    assign data_task_done                  = data_done;
    assign ins_fetched_from_memory_adaptor = ins_q;
    assign data_rdata                      = rdata_q;
    assign adaptor_busy                    = (state_q != ST_IDLE);

    // State and datapath registers; reset returns straight to IDLE
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            nbytes_q    <= 3'd0;
            is_ins_q    <= 1'b0;
            base_q      <= 32'd0;
            wdata_q     <= 32'd0;
            result_q    <= 32'd0;
            ins_q       <= 32'd0;
            rdata_q     <= 32'd0;
            pend_ins_q  <= 1'b0;
            pend_addr_q <= 32'd0;
            mem_a_q     <= '0;
            mem_dout_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            is_ins_q    <= is_ins_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            result_q    <= result_d;
            ins_q       <= ins_d;
            rdata_q     <= rdata_d;
            pend_ins_q  <= pend_ins_d;
            pend_addr_q <= pend_addr_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
        end
    end

endmodule

// File: tb/tb_memory_adaptor.sv
// Bench for memory_adaptor: byte-wide RAM on the bus, a reference memory and
// expectation queues (done cycle + value, write stream) derived from the
// latency and byte-order rules, checked every cycle by one compare process.
module tb_memory_adaptor;
    import mem_adaptor_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_pipline;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        request_ins;
    logic [31:0] insaddr;
    logic [31:0] ins_fetched;
    logic        insfetch_task_done;
    logic        data_request;
    logic        data_is_write;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_task_done;
    logic        adaptor_busy;

    memory_adaptor #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
        .clk_in                                   (clk_in),
        .rst_in                                   (rst_in),
        .rdy_in                                   (rdy_in),
        .flush_pipline                            (flush_pipline),
        .io_buffer_full                           (io_buffer_full),
        .mem_din                                  (mem_din),
        .mem_dout                                 (mem_dout),
        .mem_a                                    (mem_a),
        .mem_wr                                   (mem_wr),
        .request_ins_from_memory_adaptor          (request_ins),
        .insaddr_to_be_fetched_from_memory_adaptor(insaddr),
        .ins_fetched_from_memory_adaptor          (ins_fetched),
        .insfetch_task_done                       (insfetch_task_done),
        .data_request                             (data_request),
        .data_is_write                            (data_is_write),
        .data_size                                (data_size),
        .data_addr                                (data_addr),
        .data_wdata                               (data_wdata),
        .data_rdata                               (data_rdata),
        .data_task_done                           (data_task_done),
        .adaptor_busy                             (adaptor_busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int unsigned cyc;
        logic [31:0] val;
        logic        chk_val;
    } exp_ev_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_ev_t;

    exp_ev_t     exp_ins[$];
    exp_ev_t     exp_data[$];
    wr_ev_t      exp_wr[$];

    logic [7:0]  ram     [0:262143];
    logic [7:0]  ref_mem [0:262143];

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    logic        ins_want;
    logic        data_want;

    // Byte-wide synchronous RAM: read data appears the cycle after the address
    always @(posedge clk_in) begin
        if (mem_wr === 1'b1) ram[mem_a[17:0]] <= mem_dout;
        mem_din <= ram[mem_a[17:0]];
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    // Little-endian read from the reference memory, addresses wrapping mod 2^32
    function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
        logic [31:0] v;
        logic [31:0] a;
        v = 32'd0;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            v = v | (32'(ref_mem[a[17:0]]) << (8 * k));
        end
        return v;
    endfunction

    function automatic int model_bytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [7:0] b);
        ram[addr[17:0]]     = b;
        ref_mem[addr[17:0]] = b;
    endtask

    task automatic push_writes(input logic [31:0] addr, input logic [31:0] wd, input int n);
        wr_ev_t w;
        for (int k = 0; k < n; k++) begin
            w.addr = addr + 32'(k);
            w.data = 8'(wd >> (8 * k));
            exp_wr.push_back(w);
            ref_mem[w.addr[17:0]] = w.data;
        end
    endtask

    task automatic push_ins(input int unsigned done_cyc, input logic [31:0] addr);
        exp_ev_t e;
        e.cyc     = done_cyc;
        e.val     = model_read(addr, 4);
        e.chk_val = 1'b1;
        exp_ins.push_back(e);
        $display("txn fetch addr %h expect %h at cycle %0d", addr, e.val, done_cyc);
    endtask

    task automatic pulse_ins(input logic [31:0] addr);
        request_ins = 1'b1;
        insaddr     = addr;
        @(posedge clk_in); #1;
        request_ins = 1'b0;
    endtask

    // One LSB transaction: held until done, dropped the cycle after
    task automatic data_txn(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, input int extra);
        exp_ev_t     e;
        int          n;
        int unsigned t0;
        bit          seen;
        t0 = cyc;
        n  = model_bytes(sz);
        e.cyc     = t0 + 32'(n) + (wr ? 32'd1 : 32'd2) + 32'(extra);
        e.chk_val = !wr;
        e.val     = wr ? 32'd0 : model_read(addr, n);
        exp_data.push_back(e);
        if (wr) push_writes(addr, wd, n);
        $display("txn data %s size %0d addr %h wdata %h expect %h at cycle %0d",
                 wr ? "store" : "load", n, addr, wd, e.val, e.cyc);
        data_request  = 1'b1;
        data_is_write = wr;
        data_size     = sz;
        data_addr     = addr;
        data_wdata    = wd;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (data_task_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk_in); #1;
        data_request = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL data_txn_timeout: got no data_task_done in 200 cycles, expected one");
        end
    endtask

    // Wait (bounded) until every expected event has been consumed, then idle a little
    task automatic wait_quiet(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_ins.size() == 0 && exp_data.size() == 0 && exp_wr.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_in); #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_quiet: got %0d pending events, expected 0",
                     exp_ins.size() + exp_data.size() + exp_wr.size());
            exp_ins.delete();
            exp_data.delete();
            exp_wr.delete();
        end
        repeat (2) begin
            @(posedge clk_in); #1;
        end
    endtask

    // Per-cycle comparison of done pulses, returned data and the write stream
    always @(negedge clk_in) begin
        if (chk_en) begin
            ins_want = (exp_ins.size() > 0) && (exp_ins[0].cyc == cyc);
            checks++;
            if (insfetch_task_done !== ins_want) begin
                errors++;
                $display("FAIL ins_done cycle %0d: got %b expected %b", cyc, insfetch_task_done, ins_want);
            end
            if (ins_want) begin
                checks++;
                if (ins_fetched !== exp_ins[0].val) begin
                    errors++;
                    $display("FAIL ins_value cycle %0d: got %h expected %h", cyc, ins_fetched, exp_ins[0].val);
                end
                exp_ins.delete(0);
            end

            data_want = (exp_data.size() > 0) && (exp_data[0].cyc == cyc);
            checks++;
            if (data_task_done !== data_want) begin
                errors++;
                $display("FAIL data_done cycle %0d: got %b expected %b", cyc, data_task_done, data_want);
            end
            if (data_want) begin
                if (exp_data[0].chk_val) begin
                    checks++;
                    if (data_rdata !== exp_data[0].val) begin
                        errors++;
                        $display("FAIL data_value cycle %0d: got %h expected %h", cyc, data_rdata, exp_data[0].val);
                    end
                end
                exp_data.delete(0);
            end

            if (mem_wr === 1'b1) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write cycle %0d: got addr %h data %h expected no write", cyc, mem_a, mem_dout);
                end else begin
                    if (mem_a !== exp_wr[0].addr || mem_dout !== exp_wr[0].data) begin
                        errors++;
                        $display("FAIL write cycle %0d: got addr %h data %h expected addr %h data %h",
                                 cyc, mem_a, mem_dout, exp_wr[0].addr, exp_wr[0].data);
                    end
                    exp_wr.delete(0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish by 300000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t0;
        rst_in = 1'b0; rdy_in = 1'b1; flush_pipline = 1'b0; io_buffer_full = 1'b0;
        request_ins = 1'b0; insaddr = 32'd0;
        data_request = 1'b0; data_is_write = 1'b0; data_size = SZ_BYTE;
        data_addr = 32'd0; data_wdata = 32'd0;
        for (int i = 0; i < 262144; i++) begin
            ram[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
        preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
        preload(32'h2000, 8'hFF);
        preload(32'h2010, 8'h34); preload(32'h2011, 8'h12);
        preload(32'h0000, 8'h11); preload(32'h0001, 8'h22);
        preload(32'h0002, 8'h33); preload(32'h0003, 8'h44);
        preload(32'h3FFFE, 8'hAA); preload(32'h3FFFF, 8'hBB);

        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_mem_a", mem_a, 32'd0);
        chk("reset_mem_dout", 32'(mem_dout), 32'd0);
        chk("reset_mem_wr", 32'(mem_wr), 32'd0);
        chk("reset_ins_done", 32'(insfetch_task_done), 32'd0);
        chk("reset_data_done", 32'(data_task_done), 32'd0);
        chk("reset_data_rdata", data_rdata, 32'd0);
        chk("reset_ins_fetched", ins_fetched, 32'd0);
        chk("reset_busy", 32'(adaptor_busy), 32'd0);
        rst_in = 1'b1;
        chk_en = 1'b1;
        @(posedge clk_in); #1;

        // Word fetch: done six cycles after the pulse
        push_ins(cyc + 6, 32'h1000);
        pulse_ins(32'h1000);
        wait_quiet(50);
        chk("fetch_word_literal", ins_fetched, 32'h0000_0513);

        // Collision: data first, fetch after the IDLE gap
        t0 = cyc;
        fork
            data_txn(1'b0, SZ_BYTE, 32'h2000, 32'd0, 0);
            begin
                push_ins(t0 + 3 + 1 + 6, 32'h0);
                pulse_ins(32'h0);
            end
        join
        wait_quiet(50);
        chk("collision_data_literal", data_rdata, 32'h0000_00FF);
        chk("collision_ins_literal", ins_fetched, 32'h4433_2211);

        // Word store, then read it back
        data_txn(1'b1, SZ_WORD, 32'h3000, 32'hDEAD_BEEF, 0);
        wait_quiet(50);
        data_txn(1'b0, SZ_WORD, 32'h3000, 32'd0, 0);
        wait_quiet(50);
        chk("store_readback_literal", data_rdata, 32'hDEAD_BEEF);

        // Halfword load is zero-extended
        data_txn(1'b0, SZ_HALF, 32'h2010, 32'd0, 0);
        wait_quiet(50);
        chk("half_load_literal", data_rdata, 32'h0000_1234);

        // Fetch straddling the top of the address space
        push_ins(cyc + 6, 32'hFFFF_FFFE);
        pulse_ins(32'hFFFF_FFFE);
        wait_quiet(50);
        chk("wrap_fetch_literal", ins_fetched, 32'h2211_BBAA);

        // Flush in the third READ cycle: no done, IDLE next cycle
        pulse_ins(32'h1000);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        flush_pipline = 1'b1;
        @(posedge clk_in); #1;
        flush_pipline = 1'b0;
        chk("flush_idle_busy", 32'(adaptor_busy), 32'd0);
        $display("txn fetch addr 00001000 flushed");
        repeat (10) begin
            @(posedge clk_in); #1;
        end
        push_ins(cyc + 6, 32'h1000);
        pulse_ins(32'h1000);
        wait_quiet(50);
        chk("after_flush_fetch_literal", ins_fetched, 32'h0000_0513);

        // IO stall: five held cycles, then one write
        fork
            data_txn(1'b1, SZ_BYTE, 32'h0003_0000, 32'h41, 5);
            begin
                @(posedge clk_in); #1;
                io_buffer_full = 1'b1;
                repeat (5) begin
                    @(posedge clk_in); #1;
                end
                io_buffer_full = 1'b0;
            end
        join
        wait_quiet(50);
        data_txn(1'b0, SZ_BYTE, 32'h0003_0000, 32'd0, 0);
        wait_quiet(50);
        chk("io_store_readback_literal", data_rdata, 32'h0000_0041);

        // Pause for three cycles in the middle of a halfword store
        fork
            data_txn(1'b1, SZ_HALF, 32'h4000, 32'h0000_A5C3, 3);
            begin
                repeat (2) begin
                    @(posedge clk_in); #1;
                end
                rdy_in = 1'b0;
                repeat (3) begin
                    @(posedge clk_in); #1;
                end
                rdy_in = 1'b1;
            end
        join
        wait_quiet(50);
        data_txn(1'b0, SZ_HALF, 32'h4000, 32'd0, 0);
        wait_quiet(50);
        chk("pause_store_readback_literal", data_rdata, 32'h0000_A5C3);

        // Asynchronous reset during the third byte of a word store
        $display("txn data store size 4 addr 00005000 interrupted by reset");
        push_writes(32'h5000, 32'h1122_3344, 2);
        data_request  = 1'b1;
        data_is_write = 1'b1;
        data_size     = SZ_WORD;
        data_addr     = 32'h5000;
        data_wdata    = 32'h1122_3344;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        @(posedge clk_in); #2;
        rst_in       = 1'b0;
        data_request = 1'b0;
        #1;
        chk("midreset_mem_wr", 32'(mem_wr), 32'd0);
        chk("midreset_busy", 32'(adaptor_busy), 32'd0);
        chk("midreset_data_rdata", data_rdata, 32'd0);
        chk("midreset_ins_fetched", ins_fetched, 32'd0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        wait_quiet(20);

        // Adaptor is usable again after reset
        push_ins(cyc + 6, 32'h0);
        pulse_ins(32'h0);
        wait_quiet(50);
        chk("post_reset_fetch_literal", ins_fetched, 32'h4433_2211);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
